// File: rtl/seg_scan_controller.sv
// Scan timing for a four-digit seven-segment multiplexer: one-hot digit select,
// per-slot anti-ghosting blank, 16-level PWM brightness and per-digit masking.
module seg_scan_controller #(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned BLANK    = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] brightness,
  input  logic [3:0] digit_mask,
  output logic [3:0] select,
  output logic       enable,
  output logic       frame_start
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] BL   = 16'(BLANK);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  idx, idx_n;
  logic [3:0]  phase, phase_n;
  logic [3:0]  lat_b, lat_b_n;
  logic [3:0]  lat_m, lat_m_n;
  logic [3:0]  sel_n;
  logic        en_n, fs_n;

  // Outputs are computed from next-cycle values so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    state_n = S_IDLE;
    cnt_n   = '0;
    idx_n   = '0;
    phase_n = '0;
    lat_b_n = '0;
    lat_m_n = '0;
    sel_n   = 4'b0001;
    en_n    = 1'b0;
    fs_n    = 1'b0;
    if (run) begin
      if (state == S_IDLE) begin
        state_n = S_BLANK;
        fs_n    = 1'b1;
        lat_b_n = brightness;
        lat_m_n = digit_mask;
      end else if (cnt == LAST) begin
        state_n = S_BLANK;
        idx_n   = idx + 2'd1;
        sel_n   = {select[2:0], select[3]};
        fs_n    = (idx == 2'd3);
        lat_b_n = brightness;
        lat_m_n = digit_mask;
      end else begin
        cnt_n   = cnt + 16'd1;
        idx_n   = idx;
        sel_n   = select;
        lat_b_n = lat_b;
        lat_m_n = lat_m;
        if (cnt_n < BL) begin
          state_n = S_BLANK;
        end else begin
          state_n = S_ON;
          phase_n = (state == S_ON) ? phase + 4'd1 : '0;
          en_n    = lat_m[idx] & (phase_n < lat_b);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      phase       <= '0;
      lat_b       <= '0;
      lat_m       <= '0;
      select      <= 4'b0001;
      enable      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      phase       <= phase_n;
      lat_b       <= lat_b_n;
      lat_m       <= lat_m_n;
      select      <= sel_n;
      enable      <= en_n;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with PRESCALE=40, BLANK=4.
module tb_seg_scan_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] brightness;
  logic [3:0] digit_mask;
  logic [3:0] select;
  logic       enable;
  logic       frame_start;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned t     = 0;
  int unsigned hi    = 0;

  seg_scan_controller #(.PRESCALE(40), .BLANK(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .brightness (brightness),
    .digit_mask (digit_mask),
    .select     (select),
    .enable     (enable),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d: got %0h want %0h", tag, t, obs, exp);
    end
  endtask

  // Expected outputs for cycle t of a frame (t=0 is c=0 of slot 0).
  task automatic cyc(input logic [3:0] b, input logic [3:0] m);
    int unsigned s, c;
    logic e;
    s = (t / 40) % 4;
    c = t % 40;
    e = (c >= 4) && (((c - 4) % 16) < b) && m[s];
    chk("select", 16'(select), 16'(4'b0001 << s));
    chk("enable", 16'(enable), 16'(e));
    chk("frame_start", 16'(frame_start), 16'(t % 160 == 0));
    if (enable) hi++;
    step();
    t++;
  endtask

  // One full slot; the inputs for the following slot are applied after its
  // first cycle, i.e. after the latch edge of the current slot.
  task automatic slot(input logic [3:0] b, input logic [3:0] m, input int unsigned hi_exp,
                      input logic [3:0] nb, input logic [3:0] nm);
    hi = 0;
    cyc(b, m);
    brightness = nb;
    digit_mask = nm;
    repeat (39) cyc(b, m);
    chk("hi_count", 16'(hi), 16'(hi_exp));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; brightness = 4'd0; digit_mask = 4'd0;
    #3;
    chk("rst_select", 16'(select), 16'h1);
    chk("rst_enable", 16'(enable), 16'h0);
    chk("rst_fs", 16'(frame_start), 16'h0);
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("idle_select", 16'(select), 16'h1);
    chk("idle_enable", 16'(enable), 16'h0);
    chk("idle_fs", 16'(frame_start), 16'h0);

    // Full scan at 15/16 duty
    brightness = 4'd15; digit_mask = 4'hF; run = 1'b1;
    step(); t = 0;
    slot(15, 4'hF, 34, 15, 4'hF);
    slot(15, 4'hF, 34, 15, 4'hF);
    slot(15, 4'hF, 34, 15, 4'hF);
    slot(15, 4'hF, 34, 8, 4'hF);
    // Brightness 8
    slot(8, 4'hF, 20, 8, 4'hF);
    slot(8, 4'hF, 20, 8, 4'hF);
    slot(8, 4'hF, 20, 8, 4'hF);
    slot(8, 4'hF, 20, 0, 4'hF);
    // Brightness 0: dark but still rotating
    slot(0, 4'hF, 0, 0, 4'hF);
    slot(0, 4'hF, 0, 0, 4'hF);
    slot(0, 4'hF, 0, 0, 4'hF);
    slot(0, 4'hF, 0, 15, 4'b0101);
    // Mask 0101
    slot(15, 4'b0101, 34, 15, 4'b0101);
    slot(15, 4'b0101, 0, 15, 4'b0101);
    slot(15, 4'b0101, 34, 15, 4'b0101);
    slot(15, 4'b0101, 0, 15, 4'hF);
    // Mid-slot brightness change at o=10 of slot 1
    slot(15, 4'hF, 34, 15, 4'hF);
    hi = 0;
    repeat (14) cyc(15, 4'hF);
    brightness = 4'd4;
    repeat (26) cyc(15, 4'hF);
    chk("hi_midslot", 16'(hi), 16'd34);
    slot(4, 4'hF, 12, 4, 4'hF);
    // Stop at o=20 of slot 3
    repeat (24) cyc(4, 4'hF);
    run = 1'b0;
    cyc(4, 4'hF);
    chk("stop_enable", 16'(enable), 16'h0);
    chk("stop_select", 16'(select), 16'h1);
    chk("stop_fs", 16'(frame_start), 16'h0);
    step();
    chk("stop2_enable", 16'(enable), 16'h0);
    // Restart from slot 0
    run = 1'b1;
    step(); t = 0;
    slot(4, 4'hF, 12, 4, 4'hF);
    slot(4, 4'hF, 12, 4, 4'hF);
    // Asynchronous reset during an ON cycle of slot 2
    repeat (10) cyc(4, 4'hF);
    chk("pre_rst_select", 16'(select), 16'h4);
    #2 rst = 1'b1;
    #1;
    chk("arst_select", 16'(select), 16'h1);
    chk("arst_enable", 16'(enable), 16'h0);
    chk("arst_fs", 16'(frame_start), 16'h0);
    step();
    rst = 1'b0;
    chk("hold_fs", 16'(frame_start), 16'h0);
    step();
    chk("rel_fs", 16'(frame_start), 16'h1);
    chk("rel_select", 16'(select), 16'h1);
    chk("rel_enable", 16'(enable), 16'h0);
    step();
    chk("rel_fs_pulse", 16'(frame_start), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Timing generator that drives the four-digit seven-segment multiplexer: produces the one-hot digit `select` and the `enable` blanking/dimming strobe consumed directly by the segment multiplexer stage. It divides the system clock into fixed-length digit slots, inserts an anti-ghosting blank at the start of each slot, applies 16-level PWM brightness, and masks unused digits. It sits directly upstream of the segment multiplexer and the anode drivers.

## Interface

- `PRESCALE`, 1000: clock cycles per digit slot; legal range BLANK+1..65535.
- `BLANK`, 50: blanking cycles at the start of each slot; legal range 1..PRESCALE-1.
- `clk`  input  1  system clock; all registers on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `run`  input  1  scan enable; low forces idle (display dark).
- `brightness`  input  4  duty level; on-time per 16 ON cycles = `brightness` (0 = dark, 15 = 15/16).
- `digit_mask`  input  4  bit i = 1 lights digit i; masked digits keep their slot dark.
- `select`  output  4  one-hot digit select; bit i ⇔ digit i (0001 → A … 1000 → D).
- `enable`  output  1  high = show selected digit; low = blank.
- `frame_start`  output  1  one-cycle pulse in the first cycle of slot 0.

## Operation

- States: IDLE, BLANK, ON. All outputs are registered.
- Reset (async): state IDLE, `select`=0001, `enable`=0, `frame_start`=0, slot counter 0, digit index 0, latched brightness 0, latched mask 0000.
- IDLE: `enable`=0, `select`=0001. When `run` is sampled high, the next cycle is BLANK, cycle c=0 of slot 0, with `frame_start`=1.
- Slot counter c runs 0..PRESCALE-1. Cycles 0..BLANK-1 are BLANK. Cycles BLANK..PRESCALE-1 are ON.
- After c=PRESCALE-1: c wraps to 0, digit index increments mod 4, `select` rotates left (1000 → 0001), and the state returns to BLANK.
- `frame_start`=1 only at c=0 of slot 0.
- `brightness` and `digit_mask` are latched on the edge that enters c=0. Mid-slot changes take effect at the next slot boundary.
- BLANK: `enable`=0.
- ON: let o = c−BLANK and p = o mod 16 (4-bit PWM phase, cleared on entering ON). Then `enable` = latched_mask[index] AND (p < latched_brightness).
- Masked digits and brightness 0 still consume the full slot, so refresh rate is constant at one frame per 4·PRESCALE cycles.
- `run` sampled low in any state: the next cycle is IDLE with the reset values of all outputs and counters.
- `run` re-asserted: always restarts at slot 0 with a `frame_start` pulse. There is no resume mid-frame.
- Width: slot counter is 16 bits. No other arithmetic overflows.

## Timing

- Latency: `run` high at edge k → `frame_start`=1 and `select`=0001 after edge k+1. The first `enable` high is possible at edge k+1+BLANK.
- `select` changes only on the edge where `enable` goes to 0, and `enable` stays 0 for at least BLANK cycles afterwards.
- The downstream multiplexer registers on the same edge, so it always samples a stable (select, enable) pair. Its digit output lags `enable` by one cycle.
- Slot period = PRESCALE cycles. Frame period = 4·PRESCALE cycles. Frame rate = f_clk / (4·PRESCALE).
- `rst` asserted mid-slot: outputs reach reset values asynchronously, with no wait for a clock edge. After release, the block stays in IDLE until `run` is sampled high.

## Test plan

All scenarios use PRESCALE=40, BLANK=4.

- **Reset mid-run:** assert `rst` during an ON cycle of slot 2 → `select`=0001, `enable`=0, `frame_start`=0 before the next edge. After release with `run`=1, `frame_start` pulses 1 cycle later.
- **Full scan:** `run`=1, `brightness`=15, `digit_mask`=1111 → `select` sequence 0001, 0010, 0100, 1000, 0001, each held 40 cycles. Each slot has 4 low cycles, then 34 high cycles (low at o=15 and o=31). `frame_start` pulses every 160 cycles.
- **Brightness levels:** `brightness`=8 → `enable` high at o=0–7, 16–23, 32–35, giving 20 cycles/slot. `brightness`=0 → `enable` never high, while `select` still rotates.
- **Mask:** `digit_mask`=0101 → `enable` pulses only while `select`=0001 or 0100. Slots for 0010 and 1000 stay dark for 40 cycles each.
- **Mid-slot update:** change `brightness` 15→4 at o=10 of slot 1 → slot 1 finishes at 15/16 duty. Slot 2 shows `enable` high at o=0–3, 16–19, 32–35 only.
- **Stop/restart:** drop `run` at o=20 of slot 3 → the next cycle has `enable`=0 and `select`=0001. Raise `run` → `frame_start`=1 and slot 0 restarts with a 4-cycle BLANK.
